// File: rtl/system_pll_ctrl_pkg.sv
// Shared types and constants for the system PLL reset/lock sequencer.
package system_pll_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Largest of three cycle parameters; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/system_pll_ctrl_sync.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
// Used for pll_locked here; also suitable for resynchronising sys_rst_n
// into downstream clock domains.
module system_pll_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of an asynchronous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample on the same
      // edge; blocking here would collapse the chain into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/system_pll_ctrl.sv
// Reset/lock sequencer for the system PLL, clocked by the 50 MHz refclk.
// Pulses pll_rst, waits for a continuously stable lock, then releases
// sys_rst_n. Retries on lock timeout, parks in FAIL after MAX_RETRIES.
// Optional build macro: SYSTEM_PLL_CTRL_LOSS_CNT_EN adds loss_cnt[7:0],
// a saturating count of RUN exits caused by lock loss.
module system_pll_ctrl
  import system_pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               recal_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state_o
`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt
`endif
);

  localparam int CNT_W =
    $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lock_s;

  system_pll_ctrl_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state and retry bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no branch
    // can leave it unassigned and infer a latch.
    state_nxt = state;
    retry_nxt = retry_cnt;
    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = RESET_PLL;
          end
        end
      end
      STABLE: begin
        // A dropout restarts the lock wait without pulsing the PLL again.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s || recal_req) state_nxt = RESET_PLL;
      end
      FAIL: begin
        if (recal_req) begin
          state_nxt = RESET_PLL;
          retry_nxt = '0;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

  // State register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state <= RESET_PLL;
    else        state <= state_nxt;
  end

  // Shared cycle counter, retry count and outputs registered from next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      cnt       <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      retry_cnt <= retry_nxt;
      pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
    end
  end

  assign state_o = state;

`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
  // A RUN exit with lock_s low counts as a loss, even alongside recal_req.
  logic loss_evt;
  assign loss_evt = (state == RUN) && !lock_s;

  // Saturating lock-loss counter, cleared only by rst_n.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                           loss_cnt <= '0;
    else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_system_pll_ctrl.sv
// Self-checking bench for system_pll_ctrl (small timing parameters).
module tb_system_pll_ctrl;

  localparam int RP = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       recal_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  always #10 refclk = ~refclk;

  system_pll_ctrl #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .recal_req  (recal_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: sequencing described as a pulse length, a count of
  // consecutive locked samples and a count of unlocked samples since the
  // lock window opened.
  localparam int M_PULSE   = 0;
  localparam int M_LOCKING = 1;
  localparam int M_RUN     = 2;
  localparam int M_FAIL    = 3;

  int m_mode, m_elapsed, m_retries, m_run, m_miss, m_loss;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_mode = M_PULSE; m_elapsed = 0; m_retries = 0;
    m_run = 0; m_miss = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic start_pulse();
    m_mode = M_PULSE;
    m_elapsed = 0;
  endtask

  task automatic model_edge();
    bit ls;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
    case (m_mode)
      M_PULSE: begin
        m_elapsed++;
        if (m_elapsed == RP) begin m_mode = M_LOCKING; m_run = 0; m_miss = 0; end
      end
      M_LOCKING: begin
        if (ls) begin
          m_run++;
          if (m_run == ST + 1) begin m_mode = M_RUN; m_retries = 0; end
        end else if (m_run > 0) begin
          m_run = 0; m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss == TO) begin
            if (m_retries == MR) m_mode = M_FAIL;
            else begin m_retries++; start_pulse(); end
          end
        end
      end
      M_RUN: begin
        if (!ls || recal_req) begin
          if (!ls && m_loss < 255) m_loss++;
          start_pulse();
        end
      end
      default: begin
        if (recal_req) begin m_retries = 0; start_pulse(); end
      end
    endcase
  endtask

  task automatic check_model();
    int es;
    es = (m_mode == M_PULSE) ? 0 :
         (m_mode == M_LOCKING) ? ((m_run > 0) ? 2 : 1) :
         (m_mode == M_RUN) ? 3 : 4;
    check("m_state",   state_o,   es);
    check("m_pll_rst", pll_rst,   (m_mode == M_PULSE || m_mode == M_FAIL));
    check("m_sysrst",  sys_rst_n, (m_mode == M_RUN));
    check("m_ready",   ready,     (m_mode == M_RUN));
    check("m_fail",    fail,      (m_mode == M_FAIL));
    check("m_retry",   retry_cnt, m_retries);
`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
    check("m_loss",    loss_cnt,  m_loss);
`endif
  endtask

  // One refclk edge: advance the model with the sampled inputs, then
  // compare on the following falling edge.
  task automatic step();
    @(posedge refclk);
    model_edge();
    @(negedge refclk);
    check_model();
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < limit) begin
      step();
      n++;
    end
    check(tag, state_o, s);
  endtask

  int   n, k, pulses, maxr;
  logic prev, rose;

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; recal_req = 1'b0;
    model_reset();
    repeat (2) @(negedge refclk);

    // Reset values.
    check("rst_state",  state_o,   0);
    check("rst_pll",    pll_rst,   1);
    check("rst_sysrst", sys_rst_n, 0);
    check("rst_ready",  ready,     0);
    check("rst_fail",   fail,      0);
    check("rst_retry",  retry_cnt, 0);

    // Nominal lock.
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 50) begin step(); n++; end
    check("pulse_len", n, RP);
    repeat (10) step();
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 50) begin step(); n++; end
    check("lock_to_ready", n, 11);
    check("nom_sysrst", sys_rst_n, 1);
    check("nom_retry", retry_cnt, 0);
    repeat (5) step();

    // Lock loss in RUN.
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n && n < 20) begin step(); n++; end
    check("loss_latency", n, 3);
    check("loss_pll_rst", pll_rst, 1);
`ifdef SYSTEM_PLL_CTRL_LOSS_CNT_EN
    check("loss_cnt_one", loss_cnt, 1);
`endif
    n = 0;
    while (pll_rst && n < 20) begin step(); n++; end
    repeat ($urandom_range(1, 25)) step();
    pll_locked = 1'b1;
    wait_state(3'd3, 60, "reseq_run");

    // recal_req in RUN restarts; in WAIT_LOCK it is ignored.
    step();
    recal_req = 1'b1; step(); recal_req = 1'b0;
    check("recal_run_state", state_o, 0);
    pll_locked = 1'b0;
    wait_state(3'd1, 20, "recal_wait");
    k = $urandom_range(2, 20);
    repeat (k) step();
    recal_req = 1'b1; step(); recal_req = 1'b0;
    check("recal_ignored", state_o, 1);
    n = 0;
    while (state_o == 3'd1 && n < 60) begin step(); n++; end
    check("timeout_window", k + 1 + n, TO);
    check("retry_after_to", retry_cnt, 1);
    pll_locked = 1'b1;
    wait_state(3'd3, 80, "relock_run");

    // Timeout to FAIL.
    recal_req = 1'b1; pll_locked = 1'b0; step(); recal_req = 1'b0;
    n = 0; pulses = 1; maxr = 0; prev = pll_rst;
    while (!fail && n < 200) begin
      step(); n++;
      if (pll_rst && !prev && !fail) pulses++;
      prev = pll_rst;
      if (int'(retry_cnt) > maxr) maxr = retry_cnt;
    end
    check("fail_cycles", n, 3 * (RP + TO));
    check("fail_pulses", pulses, 3);
    check("fail_maxretry", maxr, MR);
    repeat (5) step();
    check("fail_held", fail, 1);
    recal_req = 1'b1; step(); recal_req = 1'b0;
    check("fail_recal_state", state_o, 0);
    check("fail_recal_retry", retry_cnt, 0);

    // Glitch during STABLE.
    wait_state(3'd1, 20, "glitch_wait");
    pll_locked = 1'b1;
    wait_state(3'd2, 10, "glitch_stable");
    repeat (5) step();
    pll_locked = 1'b0; step(); pll_locked = 1'b1;
    n = 0; rose = 1'b0;
    while (!ready && n < 40) begin
      step(); n++;
      if (pll_rst) rose = 1'b1;
    end
    check("glitch_to_ready", n, 11);
    check("glitch_no_pulse", rose, 0);

    // Randomised lock/recal activity against the model.
    for (int seg = 0; seg < 40; seg++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      k = $urandom_range(1, 30);
      for (int i = 0; i < k; i++) begin
        recal_req = ($urandom_range(0, 29) == 0);
        step();
      end
      recal_req = 1'b0;
    end

    // Asynchronous reset in STABLE.
    rst_n = 1'b0; model_reset();
    @(negedge refclk);
    rst_n = 1'b1; pll_locked = 1'b1;
    wait_state(3'd2, 40, "pre_reset_stable");
    repeat (2) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_state",  state_o,   0);
    check("arst_pll",    pll_rst,   1);
    check("arst_sysrst", sys_rst_n, 0);
    check("arst_ready",  ready,     0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_state(3'd3, 60, "restart_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
